// File: rtl/lpm_fifo_rd_stream.sv
// lpm_fifo_rd_stream
//   Adapts a normal-mode (one-cycle read latency) FIFO read port to a
//   valid/ready stream through a 2-entry skid buffer. Read requests are
//   throttled so the buffer occupancy plus any in-flight read never exceeds
//   two, which lets the downstream stall without losing words.
//
// Ports
//   clock       rising-edge clock (FIFO read clock)
//   sclr        synchronous clear, active-high
//   fifo_empty  FIFO empty flag
//   fifo_rreq   FIFO read request (combinational)
//   fifo_q      FIFO read data, valid the cycle after an accepted read
//   out_valid   out_data holds a word
//   out_ready   downstream accepts the word
//   out_data    head word of the skid buffer
//   usedw       skid-buffer occupancy, 0..2
module lpm_fifo_rd_stream #(
  parameter int lpm_width = 8
) (
  input  logic                 clock,
  input  logic                 sclr,
  input  logic                 fifo_empty,
  output logic                 fifo_rreq,
  input  logic [lpm_width-1:0] fifo_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [lpm_width-1:0] out_data,
  output logic [1:0]           usedw
);

  logic [1:0]           occ_q, occ_d;
  logic                 lrreq_q, lrreq_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [lpm_width-1:0] buf_q [2];
  logic [lpm_width-1:0] buf_d [2];

  logic                 pop;
  logic [2:0]           fill;

  always_comb begin
    // Stream outputs come from registers only; out_ready only steers the
    // pointer/occupancy update and the read request.
    out_valid = (occ_q != 2'd0);
    out_data  = buf_q[rd_ptr_q];
    usedw     = occ_q;
    pop       = out_valid & out_ready;

    // Occupancy after this edge, counting the word already in flight.
    // Never negative: pop implies occ_q >= 1.
    fill      = {1'b0, occ_q} + {2'b00, lrreq_q} - {2'b00, pop};
    fifo_rreq = ~sclr & ~fifo_empty & (fill < 3'd2);

    lrreq_d  = fifo_rreq;
    occ_d    = fill[1:0];
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ lrreq_q;

    // Capture is keyed on the read issued last cycle, not on fifo_empty,
    // so a word is still taken if empty rises right after the read.
    buf_d = buf_q;
    if (lrreq_q) begin
      buf_d[wr_ptr_q] = fifo_q;
    end
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      occ_q    <= '0;
      lrreq_q  <= 1'b0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      occ_q    <= occ_d;
      lrreq_q  <= lrreq_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Data registers are not cleared; out_data is don't-care while invalid.
  // During sclr lrreq_q is forced low next edge, so a held-over capture here
  // is never marked valid.
  always_ff @(posedge clock) begin
    if (!sclr) begin
      buf_q <= buf_d;
    end
  end

endmodule
